// File: rtl/axi_id_serialize_pkg.sv
// Shared types for the AXI ID serializer: channel structs, error causes and
// the counter-width helper used by the FIFO and the top level.
package axi_id_serialize_pkg;

    localparam int unsigned SlvIdW = 4;
    localparam int unsigned MstIdW = 2;
    localparam int unsigned AddrW  = 16;
    localparam int unsigned DataW  = 16;

    typedef logic [SlvIdW-1:0] slv_id_t;
    typedef logic [MstIdW-1:0] mst_id_t;

    // Why err_o was raised: a response arrived with nothing recorded.
    typedef enum logic {
        ERR_B_EMPTY = 1'b0,
        ERR_R_EMPTY = 1'b1
    } err_cause_e;

    // Bits needed to hold a count from 0 up to and including n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    typedef struct packed {
        slv_id_t          id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [5:0]       atop;
    } slv_aw_t;

    typedef struct packed {
        mst_id_t          id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [5:0]       atop;
    } mst_aw_t;

    typedef struct packed {
        slv_id_t          id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
    } slv_ar_t;

    typedef struct packed {
        mst_id_t          id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
    } mst_ar_t;

    typedef struct packed {
        logic [DataW-1:0] data;
        logic             last;
    } w_chan_t;

    typedef struct packed {
        slv_id_t    id;
        logic [1:0] resp;
    } slv_b_t;

    typedef struct packed {
        mst_id_t    id;
        logic [1:0] resp;
    } mst_b_t;

    typedef struct packed {
        slv_id_t          id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
    } slv_r_t;

    typedef struct packed {
        mst_id_t          id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
    } mst_r_t;

    typedef struct packed {
        slv_aw_t aw;
        logic    aw_valid;
        w_chan_t w;
        logic    w_valid;
        logic    b_ready;
        slv_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } slv_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   w_ready;
        slv_b_t b;
        logic   b_valid;
        logic   ar_ready;
        slv_r_t r;
        logic   r_valid;
    } slv_resp_t;

    typedef struct packed {
        mst_aw_t aw;
        logic    aw_valid;
        w_chan_t w;
        logic    w_valid;
        logic    b_ready;
        mst_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } mst_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   w_ready;
        mst_b_t b;
        logic   b_valid;
        logic   ar_ready;
        mst_r_t r;
        logic   r_valid;
    } mst_resp_t;

endpackage

// File: rtl/axi_id_fifo.sv
// In-order ID FIFO with two push ports (port 0 is written first) and one
// pop port. No fall-through: a pop frees its slot only from the next cycle.
// The caller guarantees room for both pushes when both are asserted.
module axi_id_fifo import axi_id_serialize_pkg::*; #(
    parameter int unsigned Depth = 4,
    parameter type         data_t = logic,
    localparam int unsigned CntW = cnt_width(Depth)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push0_i,
    input  data_t           data0_i,
    input  logic            push1_i,
    input  data_t           data1_i,
    input  logic            pop_i,
    output logic            full_o,
    output logic            empty_o,
    output data_t           head_o,
    output logic [CntW-1:0] cnt_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    data_t           mem_q [Depth];
    data_t           mem_d [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            push0_s, push1_s, pop_s;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end else begin
            return p + PtrW'(1);
        end
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == CntW'(0));
    assign head_o  = mem_q[rptr_q];
    assign cnt_o   = cnt_q;

    // Next-state storage, pointers and occupancy from this cycle's pushes and pop.
    always_comb begin
        push0_s = push0_i && !full_o;
        push1_s = push1_i;
        pop_s   = pop_i && !empty_o;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push0_s) begin
            mem_d[wptr_d] = data0_i;
            wptr_d        = ptr_inc(wptr_d);
        end else begin
            wptr_d = wptr_d;
        end
        if (push1_s) begin
            mem_d[wptr_d] = data1_i;
            wptr_d        = ptr_inc(wptr_d);
        end else begin
            wptr_d = wptr_d;
        end
        if (pop_s) begin
            rptr_d = ptr_inc(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end
        cnt_d = cnt_q + CntW'(push0_s) + CntW'(push1_s) - CntW'(pop_s);
    end

    // State registers; reset discards every recorded ID at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/axi_id_serialize_checker.sv
// Protocol checks on the slave-port response channels: a waiting response
// must keep its restored ID until it is accepted.
module axi_id_serialize_checker #(
    parameter type id_t = logic
) (
    input logic clk_i,
    input logic rst_i,
    input logic b_valid_i,
    input logic b_ready_i,
    input id_t  b_id_i,
    input logic r_valid_i,
    input logic r_ready_i,
    input id_t  r_id_i
);

    // B id holds while the response is stalled.
    b_id_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (b_valid_i && !b_ready_i) |=> (!b_valid_i || $stable(b_id_i)));

    // R id holds while the beat is stalled.
    r_id_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_valid_i && !r_ready_i) |=> (!r_valid_i || $stable(r_id_i)));

endmodule

// File: rtl/axi_id_serialize_restore.sv
// Replaces AW/AR IDs with fixed master-port IDs and restores the original
// IDs on B and R from in-order FIFOs. All channels are combinational.
module axi_id_serialize_restore import axi_id_serialize_pkg::*; #(
    parameter int unsigned MaxWrTxns  = 4,
    parameter int unsigned MaxRdTxns  = 4,
    parameter type         slv_id_t   = axi_id_serialize_pkg::slv_id_t,
    parameter type         mst_id_t   = axi_id_serialize_pkg::mst_id_t,
    parameter mst_id_t     MstAwId    = '0,
    parameter mst_id_t     MstArId    = '0,
    parameter type         slv_req_t  = axi_id_serialize_pkg::slv_req_t,
    parameter type         slv_resp_t = axi_id_serialize_pkg::slv_resp_t,
    parameter type         mst_req_t  = axi_id_serialize_pkg::mst_req_t,
    parameter type         mst_resp_t = axi_id_serialize_pkg::mst_resp_t,
    localparam int unsigned WrCntW    = cnt_width(MaxWrTxns),
    localparam int unsigned RdCntW    = cnt_width(MaxRdTxns)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  slv_req_t          slv_req_i,
    output slv_resp_t         slv_resp_o,
    output mst_req_t          mst_req_o,
    input  mst_resp_t         mst_resp_i,
    output logic [WrCntW-1:0] wr_cnt_o,
    output logic [RdCntW-1:0] rd_cnt_o,
    output logic              err_o
);

    logic    wr_full_s, wr_empty_s, rd_full_s, rd_empty_s;
    slv_id_t wr_head_s, rd_head_s;
    logic    aw_atop_rd_s, wr_ok_s, ar_ok_s;
    logic    aw_hs_s, ar_hs_s, b_pop_s, r_pop_s;
    logic    err_q, err_d;

    // Admission: an ATOP with R response needs room in both FIFOs, and it
    // takes the last free read slot ahead of a concurrent AR.
    always_comb begin
        aw_atop_rd_s = slv_req_i.aw.atop[5];
        wr_ok_s      = !wr_full_s && (!aw_atop_rd_s || !rd_full_s);
        ar_ok_s      = !rd_full_s &&
                       !(slv_req_i.aw_valid && aw_atop_rd_s &&
                         (rd_cnt_o >= RdCntW'(MaxRdTxns - 1)));
        aw_hs_s      = slv_req_i.aw_valid && mst_resp_i.aw_ready && wr_ok_s;
        ar_hs_s      = slv_req_i.ar_valid && mst_resp_i.ar_ready && ar_ok_s;
        b_pop_s      = mst_resp_i.b_valid && slv_req_i.b_ready && !wr_empty_s;
        r_pop_s      = mst_resp_i.r_valid && slv_req_i.r_ready &&
                       mst_resp_i.r.last && !rd_empty_s;
        err_d        = err_q ||
                       (mst_resp_i.b_valid && wr_empty_s) ||
                       (mst_resp_i.r_valid && rd_empty_s);
    end

    // Sticky error flag: set by any response that has no recorded ID.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

    axi_id_fifo #(.Depth(MaxWrTxns), .data_t(slv_id_t)) i_wr_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push0_i (aw_hs_s),
        .data0_i (slv_req_i.aw.id),
        .push1_i (1'b0),
        .data1_i ('0),
        .pop_i   (b_pop_s),
        .full_o  (wr_full_s),
        .empty_o (wr_empty_s),
        .head_o  (wr_head_s),
        .cnt_o   (wr_cnt_o)
    );

    axi_id_fifo #(.Depth(MaxRdTxns), .data_t(slv_id_t)) i_rd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push0_i (aw_hs_s && aw_atop_rd_s),
        .data0_i (slv_req_i.aw.id),
        .push1_i (ar_hs_s),
        .data1_i (slv_req_i.ar.id),
        .pop_i   (r_pop_s),
        .full_o  (rd_full_s),
        .empty_o (rd_empty_s),
        .head_o  (rd_head_s),
        .cnt_o   (rd_cnt_o)
    );

    // Downstream request: fixed IDs, gated valids, everything else copied.
    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw.id    = MstAwId;
        mst_req_o.aw.addr  = slv_req_i.aw.addr;
        mst_req_o.aw.len   = slv_req_i.aw.len;
        mst_req_o.aw.atop  = slv_req_i.aw.atop;
        mst_req_o.aw_valid = slv_req_i.aw_valid && wr_ok_s;
        mst_req_o.w        = slv_req_i.w;
        mst_req_o.w_valid  = slv_req_i.w_valid;
        mst_req_o.b_ready  = slv_req_i.b_ready;
        mst_req_o.ar.id    = MstArId;
        mst_req_o.ar.addr  = slv_req_i.ar.addr;
        mst_req_o.ar.len   = slv_req_i.ar.len;
        mst_req_o.ar_valid = slv_req_i.ar_valid && ar_ok_s;
        mst_req_o.r_ready  = slv_req_i.r_ready;
    end

    // Upstream response: restored IDs (zero when nothing is recorded).
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready && wr_ok_s;
        slv_resp_o.w_ready  = mst_resp_i.w_ready;
        slv_resp_o.b.id     = wr_empty_s ? slv_id_t'(0) : wr_head_s;
        slv_resp_o.b.resp   = mst_resp_i.b.resp;
        slv_resp_o.b_valid  = mst_resp_i.b_valid;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready && ar_ok_s;
        slv_resp_o.r.id     = rd_empty_s ? slv_id_t'(0) : rd_head_s;
        slv_resp_o.r.data   = mst_resp_i.r.data;
        slv_resp_o.r.resp   = mst_resp_i.r.resp;
        slv_resp_o.r.last   = mst_resp_i.r.last;
        slv_resp_o.r_valid  = mst_resp_i.r_valid;
    end

    axi_id_serialize_checker #(.id_t(slv_id_t)) i_checker (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .b_valid_i (slv_resp_o.b_valid),
        .b_ready_i (slv_req_i.b_ready),
        .b_id_i    (slv_resp_o.b.id),
        .r_valid_i (slv_resp_o.r_valid),
        .r_ready_i (slv_req_i.r_ready),
        .r_id_i    (slv_resp_o.r.id)
    );

endmodule

// File: tb/tb_axi_id_serialize_restore.sv
// Bench for axi_id_serialize_restore: directed scenarios plus random traffic,
// checked by a queue-based reference model sampled on the falling edge.
module tb_axi_id_serialize_restore;
    import axi_id_serialize_pkg::*;

    localparam int unsigned MAXW = 4;
    localparam int unsigned MAXR = 4;
    localparam mst_id_t MST_AW_ID = 2'd2;
    localparam mst_id_t MST_AR_ID = 2'd1;

    logic      clk = 1'b0;
    logic      rst;
    slv_req_t  slv_req;
    slv_resp_t slv_resp;
    mst_req_t  mst_req;
    mst_resp_t mst_resp;
    logic [2:0] wr_cnt, rd_cnt;
    logic      err;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    slv_id_t wq[$];
    slv_id_t rq[$];
    bit      m_err;
    int      wn, rn;
    bit      atop5, wr_ok, ar_ok, aw_hs, ar_hs;

    axi_id_serialize_restore #(
        .MaxWrTxns (MAXW),
        .MaxRdTxns (MAXR),
        .MstAwId   (MST_AW_ID),
        .MstArId   (MST_AR_ID)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp),
        .wr_cnt_o   (wr_cnt),
        .rd_cnt_o   (rd_cnt),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        slv_req.aw_valid    = 1'b0;
        slv_req.ar_valid    = 1'b0;
        slv_req.w_valid     = 1'b0;
        slv_req.b_ready     = 1'b1;
        slv_req.r_ready     = 1'b1;
        slv_req.aw.atop     = 6'd0;
        mst_resp.aw_ready   = 1'b1;
        mst_resp.ar_ready   = 1'b1;
        mst_resp.w_ready    = 1'b1;
        mst_resp.b_valid    = 1'b0;
        mst_resp.r_valid    = 1'b0;
        mst_resp.r.last     = 1'b0;
    endtask

    // Reference model: predicts every output from queues of recorded IDs,
    // then advances the queues by the handshakes of this cycle.
    always @(negedge clk) begin
        if (rst) begin
            wq.delete();
            rq.delete();
            m_err = 1'b0;
            chk("rst_wr_cnt", wr_cnt, 0);
            chk("rst_rd_cnt", rd_cnt, 0);
            chk("rst_err", err, 0);
        end else begin
            wn    = wq.size();
            rn    = rq.size();
            atop5 = slv_req.aw.atop[5];
            wr_ok = (wn < MAXW) && (!atop5 || rn < MAXR);
            ar_ok = (rn < MAXR) && !(slv_req.aw_valid && atop5 && (MAXR - rn) <= 1);
            chk("wr_cnt", wr_cnt, wn);
            chk("rd_cnt", rd_cnt, rn);
            chk("err", err, m_err);
            chk("aw_ready", slv_resp.aw_ready, mst_resp.aw_ready && wr_ok);
            chk("mst_aw_valid", mst_req.aw_valid, slv_req.aw_valid && wr_ok);
            chk("ar_ready", slv_resp.ar_ready, mst_resp.ar_ready && ar_ok);
            chk("mst_ar_valid", mst_req.ar_valid, slv_req.ar_valid && ar_ok);
            chk("mst_aw_id", mst_req.aw.id, MST_AW_ID);
            chk("mst_ar_id", mst_req.ar.id, MST_AR_ID);
            chk("mst_aw_addr", mst_req.aw.addr, slv_req.aw.addr);
            chk("mst_aw_atop", mst_req.aw.atop, slv_req.aw.atop);
            chk("mst_ar_addr", mst_req.ar.addr, slv_req.ar.addr);
            chk("w_data", mst_req.w.data, slv_req.w.data);
            chk("b_valid", slv_resp.b_valid, mst_resp.b_valid);
            chk("r_valid", slv_resp.r_valid, mst_resp.r_valid);
            chk("b_ready", mst_req.b_ready, slv_req.b_ready);
            chk("r_ready", mst_req.r_ready, slv_req.r_ready);
            if (mst_resp.b_valid) begin
                chk("b_id", slv_resp.b.id, (wn > 0) ? wq[0] : slv_id_t'(0));
                chk("b_resp", slv_resp.b.resp, mst_resp.b.resp);
            end
            if (mst_resp.r_valid) begin
                chk("r_id", slv_resp.r.id, (rn > 0) ? rq[0] : slv_id_t'(0));
                chk("r_data", slv_resp.r.data, mst_resp.r.data);
                chk("r_last", slv_resp.r.last, mst_resp.r.last);
            end
            aw_hs = slv_req.aw_valid && mst_resp.aw_ready && wr_ok;
            ar_hs = slv_req.ar_valid && mst_resp.ar_ready && ar_ok;
            if ((mst_resp.b_valid && wn == 0) || (mst_resp.r_valid && rn == 0)) m_err = 1'b1;
            if (mst_resp.b_valid && slv_req.b_ready && wn > 0) void'(wq.pop_front());
            if (mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last && rn > 0) void'(rq.pop_front());
            if (aw_hs) begin
                wq.push_back(slv_req.aw.id);
                if (atop5) rq.push_back(slv_req.aw.id);
            end
            if (ar_hs) rq.push_back(slv_req.ar.id);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        slv_id_t    aw_ids [3];
        slv_id_t    ar_ids [5];
        slv_id_t    drain_ids [4];
        int         tries;
        bit         acc;
        err_cause_e cause;

        aw_ids    = '{4'd3, 4'd7, 4'd1};
        ar_ids    = '{4'd5, 4'd5, 4'd2, 4'd9, 4'd4};
        drain_ids = '{4'd11, 4'd12, 4'd2, 4'd3};
        slv_req   = '0;
        mst_resp  = '0;
        rst       = 1'b1;
        idle();
        repeat (3) step();
        rst = 1'b0;
        step();

        // writes 3,7,1 then three B responses
        for (int i = 0; i < 3; i++) begin
            slv_req.aw_valid = 1'b1;
            slv_req.aw.id    = aw_ids[i];
            slv_req.aw.addr  = 16'(i * 16);
            settle();
            chk("aw_fixed_id", mst_req.aw.id, MST_AW_ID);
            chk("aw_cnt_up", wr_cnt, i);
            step();
        end
        slv_req.aw_valid = 1'b0;
        settle();
        chk("aw_cnt_3", wr_cnt, 3);
        for (int i = 0; i < 3; i++) begin
            mst_resp.b_valid = 1'b1;
            mst_resp.b.resp  = 2'(i);
            settle();
            chk("b_order", slv_resp.b.id, aw_ids[i]);
            chk("b_cnt_down", wr_cnt, 3 - i);
            step();
        end
        mst_resp.b_valid = 1'b0;
        settle();
        chk("b_cnt_0", wr_cnt, 0);

        // five reads with the read FIFO depth four
        for (int i = 0; i < 4; i++) begin
            slv_req.ar_valid = 1'b1;
            slv_req.ar.id    = ar_ids[i];
            step();
        end
        slv_req.ar.id = ar_ids[4];
        settle();
        chk("ar_full_cnt", rd_cnt, 4);
        chk("ar_full_ready", slv_resp.ar_ready, 0);
        chk("ar_full_mst_valid", mst_req.ar_valid, 0);
        step();
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b1;
        mst_resp.r.data  = 16'hbeef;
        settle();
        chk("r_restore_5", slv_resp.r.id, 5);
        chk("ar_no_bypass", slv_resp.ar_ready, 0);
        step();
        mst_resp.r_valid = 1'b0;
        settle();
        chk("ar_after_pop", slv_resp.ar_ready, 1);
        chk("ar_after_pop_cnt", rd_cnt, 3);
        step();
        slv_req.ar_valid = 1'b0;
        settle();
        chk("ar_fifth_in", rd_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            mst_resp.r_valid = 1'b1;
            mst_resp.r.last  = 1'b1;
            mst_resp.r.data  = 16'($urandom);
            step();
        end
        mst_resp.r_valid = 1'b0;

        // one burst of four beats with random r_ready stalls
        slv_req.ar_valid = 1'b1;
        slv_req.ar.id    = 4'd6;
        slv_req.ar.len   = 8'd3;
        step();
        slv_req.ar_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mst_resp.r_valid = 1'b1;
            mst_resp.r.last  = (b == 3);
            mst_resp.r.data  = 16'($urandom);
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 20) begin
                slv_req.r_ready = (tries >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                settle();
                chk("burst_id", slv_resp.r.id, 6);
                chk("burst_cnt", rd_cnt, 1);
                acc = slv_req.r_ready;
                tries++;
                step();
            end
            if (!acc) chk("burst_bound", 0, 1);
        end
        mst_resp.r_valid = 1'b0;
        slv_req.r_ready  = 1'b1;
        settle();
        chk("burst_cnt_0", rd_cnt, 0);

        // ATOP with R response against a nearly full read FIFO
        for (int i = 0; i < 3; i++) begin
            slv_req.ar_valid = 1'b1;
            slv_req.ar.id    = slv_id_t'(10 + i);
            step();
        end
        slv_req.ar_valid = 1'b0;
        slv_req.aw_valid = 1'b1;
        slv_req.aw.id    = 4'd2;
        slv_req.aw.atop  = 6'b100000;
        settle();
        chk("atop_ready", slv_resp.aw_ready, 1);
        step();
        slv_req.aw.id = 4'd3;
        settle();
        chk("atop_wr_cnt", wr_cnt, 1);
        chk("atop_rd_cnt", rd_cnt, 4);
        chk("atop_stall", slv_resp.aw_ready, 0);
        step();
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b1;
        settle();
        chk("atop_stall_pop", slv_resp.aw_ready, 0);
        chk("atop_r_head", slv_resp.r.id, 10);
        step();
        mst_resp.r_valid = 1'b0;
        settle();
        chk("atop_go", slv_resp.aw_ready, 1);
        step();
        slv_req.aw_valid = 1'b0;
        slv_req.aw.atop  = 6'd0;
        mst_resp.b_valid = 1'b1;
        settle();
        chk("atop_b_id", slv_resp.b.id, 2);
        step();
        step();
        mst_resp.b_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mst_resp.r_valid = 1'b1;
            mst_resp.r.last  = 1'b1;
            settle();
            chk("atop_r_order", slv_resp.r.id, drain_ids[i]);
            step();
        end
        mst_resp.r_valid = 1'b0;

        // B with nothing recorded: forwarded with id 0, sticky error
        cause = ERR_B_EMPTY;
        mst_resp.b_valid = 1'b1;
        settle();
        chk("err_b_id_zero", slv_resp.b.id, 0);
        chk("err_not_yet", err, 0);
        step();
        mst_resp.b_valid = 1'b0;
        settle();
        chk($sformatf("err_set_%s", cause.name()), err, 1);
        chk("err_wr_cnt", wr_cnt, 0);
        step();
        step();
        chk("err_sticky", err, 1);

        // asynchronous reset in the middle of a read burst
        slv_req.ar_valid = 1'b1;
        slv_req.ar.id    = 4'd1;
        step();
        slv_req.ar.id = 4'd2;
        step();
        slv_req.ar_valid = 1'b0;
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b0;
        settle();
        chk("pre_rst_rd_cnt", rd_cnt, 2);
        rst = 1'b1;
        settle();
        chk("async_rst_rd", rd_cnt, 0);
        chk("async_rst_wr", wr_cnt, 0);
        chk("async_rst_err", err, 0);
        step();
        mst_resp.r_valid = 1'b0;
        step();
        rst = 1'b0;
        step();

        // random traffic with a legal downstream
        for (int c = 0; c < 600; c++) begin
            slv_req.aw_valid  = 1'($urandom_range(0, 1));
            slv_req.aw.id     = slv_id_t'($urandom);
            slv_req.aw.addr   = 16'($urandom);
            slv_req.aw.atop   = ($urandom_range(0, 3) == 0) ? 6'(6'b100000 | 6'($urandom_range(0, 31))) : 6'd0;
            slv_req.ar_valid  = 1'($urandom_range(0, 1));
            slv_req.ar.id     = slv_id_t'($urandom);
            slv_req.ar.addr   = 16'($urandom);
            slv_req.w_valid   = 1'($urandom_range(0, 1));
            slv_req.w.data    = 16'($urandom);
            slv_req.b_ready   = 1'($urandom_range(0, 1));
            slv_req.r_ready   = 1'($urandom_range(0, 1));
            mst_resp.aw_ready = 1'($urandom_range(0, 1));
            mst_resp.ar_ready = 1'($urandom_range(0, 1));
            mst_resp.b_valid  = (wq.size() > 0) && ($urandom_range(0, 2) == 0);
            mst_resp.b.resp   = 2'($urandom);
            mst_resp.r_valid  = (rq.size() > 0) && ($urandom_range(0, 2) == 0);
            mst_resp.r.last   = 1'($urandom_range(0, 1));
            mst_resp.r.data   = 16'($urandom);
            step();
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
